// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a six-digit multiplexed 7-segment scan bus, decodes each frame back
// to binary time and publishes it once it has been seen STABLE_FRAMES times in a row.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_seg_enb,
    input  logic [6:0] i_seg,
    input  logic       i_seg_dp,
    output logic [5:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [5:0] o_dp,
    output logic [5:0] o_blank,
    output logic       o_upd,
    output logic       o_err,
    output logic       o_no_scan
);

    localparam int unsigned    ToW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]     SettleMax = 8'(SETTLE_CYC);
    localparam logic [3:0]     StableReq = 4'(STABLE_FRAMES);
    localparam logic [ToW-1:0] ToMax     = ToW'(TIMEOUT);

    // Result packing: {invalid, blank, bcd[3:0]}
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b1111110: r = 6'd0;
            7'b0110000: r = 6'd1;
            7'b1101101: r = 6'd2;
            7'b1111001: r = 6'd3;
            7'b0110011: r = 6'd4;
            7'b1011011: r = 6'd5;
            7'b1011111: r = 6'd6;
            7'b1110000: r = 6'd7;
            7'b1111111: r = 6'd8;
            7'b1111011: r = 6'd9;
            7'b0000000: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return {3'b000, tens} * 7'd10 + {3'b000, ones};
    endfunction

    // Capture stage
    logic [5:0]      enb_q;
    logic [7:0]      settle_q, settle_d;
    logic [5:0]      cap_q, cap_d;
    logic [5:0][6:0] slot_seg_q, slot_seg_d;
    logic [5:0]      slot_dp_q, slot_dp_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [5:0]      enb_zero;
    logic            enb_chg, enb_multi, enb_legal, enb_err, capture, frame_done;

    // Decode stage
    logic [5:0][5:0] dec_raw;
    logic [5:0][3:0] dec_bcd;
    logic [5:0]      dec_blank;
    logic            dec_bad;

    logic            s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
    logic [5:0][3:0] s1_bcd_q, s1_bcd_d;
    logic [5:0]      s1_dp_q, s1_dp_d, s1_blank_q, s1_blank_d;

    // Stability / commit stage
    logic [3:0]      stab_q, stab_d;
    logic [5:0][3:0] ref_bcd_q, ref_bcd_d, com_bcd_q, com_bcd_d;
    logic [5:0]      ref_dp_q, ref_dp_d, ref_blank_q, ref_blank_d;
    logic [5:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [5:0]      dp_q, dp_d, blank_q, blank_d;
    logic            upd_q, upd_d, err_q, err_d;
    logic            same_ref, same_com;

    always_comb begin
        enb_zero  = ~i_seg_enb;
        enb_chg   = (i_seg_enb != enb_q);
        enb_multi = (enb_zero & (enb_zero - 6'd1)) != 6'd0;
        enb_legal = (enb_zero != 6'd0) && !enb_multi;
        enb_err   = enb_chg && enb_multi;

        if (!enb_legal)                settle_d = 8'd0;
        else if (enb_chg)              settle_d = 8'd1;
        else if (settle_q < SettleMax) settle_d = settle_q + 8'd1;
        else                           settle_d = settle_q;

        // Fire only on the cycle the count arrives at SETTLE_CYC, not while it sits saturated
        capture = enb_legal && (settle_d == SettleMax) && (enb_chg || settle_q != SettleMax);

        slot_seg_d = slot_seg_q;
        slot_dp_d  = slot_dp_q;
        cap_d      = cap_q;
        for (int k = 0; k < 6; k++) begin
            if (capture && enb_zero[k]) begin
                slot_seg_d[k] = i_seg;
                slot_dp_d[k]  = i_seg_dp;
                cap_d[k]      = 1'b1;
            end
        end
        frame_done = capture && (cap_d == 6'h3F);
        if (frame_done || enb_err) cap_d = 6'h00;

        if (capture)            to_d = '0;
        else if (to_q == ToMax) to_d = to_q;
        else                    to_d = to_q + ToW'(1);
    end

    always_comb begin
        dec_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dec_raw[k]   = seg_decode(slot_seg_d[k]);
            dec_blank[k] = dec_raw[k][4];
            dec_bcd[k]   = dec_raw[k][4] ? com_bcd_q[k] : dec_raw[k][3:0];
            if (dec_raw[k][5]) dec_bad = 1'b1;
        end
        if (dec_bcd[5] > 4'd2 || to_bin(dec_bcd[5], dec_bcd[4]) > 7'd23 ||
            dec_bcd[3] > 4'd5 || dec_bcd[1] > 4'd5) begin
            dec_bad = 1'b1;
        end

        s1_vld_d   = frame_done || enb_err;
        s1_err_d   = enb_err || dec_bad;
        s1_bcd_d   = dec_bcd;
        s1_dp_d    = slot_dp_d;
        s1_blank_d = dec_blank;
    end

    always_comb begin
        stab_d      = stab_q;
        ref_bcd_d   = ref_bcd_q;
        ref_dp_d    = ref_dp_q;
        ref_blank_d = ref_blank_q;
        com_bcd_d   = com_bcd_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        dp_d        = dp_q;
        blank_d     = blank_q;
        upd_d       = 1'b0;
        err_d       = 1'b0;

        same_ref = (s1_bcd_q == ref_bcd_q) && (s1_dp_q == ref_dp_q) &&
                   (s1_blank_q == ref_blank_q);
        same_com = (s1_bcd_q == com_bcd_q) && (s1_dp_q == dp_q) && (s1_blank_q == blank_q);

        if (s1_vld_q) begin
            if (s1_err_q) begin
                stab_d = 4'd0;
                err_d  = 1'b1;
            end else begin
                if (same_ref) begin
                    stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
                end else begin
                    ref_bcd_d   = s1_bcd_q;
                    ref_dp_d    = s1_dp_q;
                    ref_blank_d = s1_blank_q;
                    stab_d      = 4'd1;
                end
                if (stab_d >= StableReq && !same_com) begin
                    com_bcd_d = s1_bcd_q;
                    dp_d      = s1_dp_q;
                    blank_d   = s1_blank_q;
                    hour_d    = 6'(to_bin(s1_bcd_q[5], s1_bcd_q[4]));
                    min_d     = 6'(to_bin(s1_bcd_q[3], s1_bcd_q[2]));
                    sec_d     = 6'(to_bin(s1_bcd_q[1], s1_bcd_q[0]));
                    upd_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_q       <= 6'h3F;
            settle_q    <= '0;
            cap_q       <= '0;
            slot_seg_q  <= '0;
            slot_dp_q   <= '0;
            to_q        <= '0;
            s1_vld_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_bcd_q    <= '0;
            s1_dp_q     <= '0;
            s1_blank_q  <= '0;
            stab_q      <= '0;
            ref_bcd_q   <= '0;
            ref_dp_q    <= '0;
            ref_blank_q <= '0;
            com_bcd_q   <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            dp_q        <= '0;
            blank_q     <= '0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            enb_q       <= i_seg_enb;
            settle_q    <= settle_d;
            cap_q       <= cap_d;
            slot_seg_q  <= slot_seg_d;
            slot_dp_q   <= slot_dp_d;
            to_q        <= to_d;
            s1_vld_q    <= s1_vld_d;
            s1_err_q    <= s1_err_d;
            s1_bcd_q    <= s1_bcd_d;
            s1_dp_q     <= s1_dp_d;
            s1_blank_q  <= s1_blank_d;
            stab_q      <= stab_d;
            ref_bcd_q   <= ref_bcd_d;
            ref_dp_q    <= ref_dp_d;
            ref_blank_q <= ref_blank_d;
            com_bcd_q   <= com_bcd_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign o_hour    = hour_q;
    assign o_min     = min_q;
    assign o_sec     = sec_q;
    assign o_dp      = dp_q;
    assign o_blank   = blank_q;
    assign o_upd     = upd_q;
    assign o_err     = err_q;
    assign o_no_scan = (to_q == ToMax);

endmodule
